// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage (ALU op classes, R-type functs, mul FSM states)
package ex_pkg;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;
  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_SLT = 3'b100;
  localparam logic [2:0] F_SLL = 3'b101;
  localparam logic [2:0] F_SRL = 3'b110;
  localparam logic [2:0] F_MUL = 3'b111;
  typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/ex_iter_mul.sv
// ex_iter_mul: shift-add multiplier datapath; one partial product per step, product valid when last=1
module ex_iter_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, addend;
  logic [CW-1:0]    count_q, count_d;
  // product already folds in the current step so the final result can leave on the last step
  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    product  = acc_q + addend;
    last     = count_q == CW'(1);
    mcand_d  = start ? a : step ? mcand_q << 1 : mcand_q;
    mplier_d = start ? b : step ? mplier_q >> 1 : mplier_q;
    acc_d    = start ? '0 : step ? product : acc_q;
    count_d  = start ? CW'(WIDTH) : step ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered execute stage with valid/ready handshake, EX/MEM register,
// iterative multiplier and flush
module ex_stage_pipe import ex_pkg::*; #(
  parameter int WIDTH   = 16,
  parameter int FUNCT_W = 3,
  parameter int SHAMT_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               branch,
  input  logic               alu_src,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   pc4,
  input  logic [WIDTH-1:0]   imm,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_result,
  output logic               zero,
  output logic [WIDTH-1:0]   branch_target,
  output logic               branch_taken,
  output logic               busy
);
  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d, zero_q, zero_d, taken_q, taken_d, mbr_q, mbr_d;
  logic [WIDTH-1:0] result_q, result_d, target_q, target_d, mtgt_q, mtgt_d;
  logic [WIDTH-1:0] op2, alu_res, target, res;
  logic [2:0]       fn;
  logic [SHAMT_W-1:0] shamt;
  logic             out_free, accept, is_mul, mul_start, mul_step, mul_last, mul_done, load;
  logic [WIDTH-1:0] mul_product;
  always_comb begin
    op2   = alu_src ? imm : data2;
    fn    = alu_op == ALUOP_RTYPE ? funct[2:0] : alu_op == ALUOP_SUB ? F_SUB : F_ADD;
    shamt = op2[SHAMT_W-1:0];
    case (fn)
      F_ADD:   alu_res = data1 + op2;
      F_SUB:   alu_res = data1 - op2;
      F_AND:   alu_res = data1 & op2;
      F_OR:    alu_res = data1 | op2;
      F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(op2)};
      F_SLL:   alu_res = data1 << shamt;
      F_SRL:   alu_res = data1 >> shamt;
      default: alu_res = '0;
    endcase
    target = pc4 + (imm << 1);
  end
  always_comb begin
    out_free  = !out_valid_q || out_ready;
    in_ready  = state_q == ST_IDLE && out_free && !flush;
    accept    = in_valid && in_ready;
    is_mul    = fn == F_MUL;
    mul_start = accept && is_mul;
    // a finished product parks on its last step until the output register can take it
    mul_step  = state_q == ST_MUL && !(mul_last && !out_free);
    mul_done  = state_q == ST_MUL && mul_last && out_free && !flush;
    load      = (accept && !is_mul) || mul_done;
    res       = mul_done ? mul_product : alu_res;
    state_d     = flush ? ST_IDLE : mul_start ? ST_MUL : mul_done ? ST_IDLE : state_q;
    out_valid_d = flush ? 1'b0 : load ? 1'b1 : out_valid_q && !out_ready;
    result_d    = load ? res : result_q;
    zero_d      = load ? res == '0 : zero_q;
    target_d    = load ? (mul_done ? mtgt_q : target) : target_q;
    taken_d     = load ? (mul_done ? mbr_q : branch) && res == '0 : taken_q;
    mtgt_d      = mul_start ? target : mtgt_q;
    mbr_d       = mul_start ? branch : mbr_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      target_q    <= '0;
      taken_q     <= 1'b0;
      mtgt_q      <= '0;
      mbr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      target_q    <= target_d;
      taken_q     <= taken_d;
      mtgt_q      <= mtgt_d;
      mbr_q       <= mbr_d;
    end
  end
  ex_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .step    (mul_step),
    .a       (data1),
    .b       (op2),
    .last    (mul_last),
    .product (mul_product)
  );
  assign out_valid     = out_valid_q;
  assign alu_result    = result_q;
  assign zero          = zero_q;
  assign branch_target = target_q;
  assign branch_taken  = taken_q;
  assign busy          = state_q == ST_MUL;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed stimulus, queue-based reference model and per-cycle compare
module tb_ex_stage_pipe;
  localparam int W = 16;
  logic clock = 0, reset_n = 0, flush = 0, in_valid = 0, branch = 0, alu_src = 0, out_ready = 1;
  logic [1:0] alu_op = 0;
  logic [2:0] funct = 0;
  logic [W-1:0] pc4 = 0, imm = 0, data1 = 0, data2 = 0;
  logic in_ready, out_valid, zero, branch_taken, busy;
  logic [W-1:0] alu_result, branch_target;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct packed {logic [W-1:0] res, tgt; logic z, tk; int rdy;} exp_t;
  exp_t q[$];
  logic ev, busy_e, ir_e;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ex_stage_pipe #(.WIDTH(W), .FUNCT_W(3), .SHAMT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .branch(branch), .alu_src(alu_src), .alu_op(alu_op), .funct(funct), .pc4(pc4), .imm(imm),
    .data1(data1), .data2(data2), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
    .branch_taken(branch_taken), .busy(busy)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic exp_t model();
    exp_t m;
    logic [W-1:0] b = alu_src ? imm : data2;
    int f = alu_op == 2'b10 ? int'(funct) : alu_op == 2'b01 ? 1 : 0;
    case (f)
      0: m.res = data1 + b;
      1: m.res = data1 - b;
      2: m.res = data1 & b;
      3: m.res = data1 | b;
      4: m.res = (int'($signed(data1)) < int'($signed(b))) ? 1 : 0;
      5: m.res = W'(int'(data1) * (2 ** int'(b[3:0])));
      6: m.res = W'(int'(data1) / (2 ** int'(b[3:0])));
      default: m.res = W'(int'(data1) * int'(b));
    endcase
    m.z   = m.res == 0;
    m.tgt = W'(int'(pc4) + 2 * int'(imm));
    m.tk  = branch && m.z;
    m.rdy = cyc + (f == 7 ? W + 1 : 1);
    return m;
  endfunction

  always @(negedge clock) begin
    if (!reset_n || flush) q.delete();
    else begin
      ev     = q.size() > 0 && cyc >= q[0].rdy;
      busy_e = q.size() > 0 && cyc < q[0].rdy;
      ir_e   = !busy_e && (!ev || out_ready);
      chk("out_valid", W'(out_valid), W'(ev));
      chk("busy", W'(busy), W'(busy_e));
      chk("in_ready", W'(in_ready), W'(ir_e));
      if (ev && out_valid) begin
        chk("alu_result", alu_result, q[0].res);
        chk("zero", W'(zero), W'(q[0].z));
        chk("branch_target", branch_target, q[0].tgt);
        chk("branch_taken", W'(branch_taken), W'(q[0].tk));
      end
      if (ev && out_ready) void'(q.pop_front());
      if (in_valid && ir_e) q.push_back(model());
    end
  end

  task automatic op(input logic [1:0] a, input logic [2:0] f, input logic br,
                    input logic [W-1:0] p, i, d1, d2);
    int n = 0;
    alu_op = a; funct = f; branch = br; alu_src = 0; pc4 = p; imm = i; data1 = d1; data2 = d2;
    in_valid = 1;
    do begin @(negedge clock); n++; end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clock); #1 in_valid = 0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 40) begin @(posedge clock); #1; n++; end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
    end
  endtask

  logic [2:0]   fv[4] = '{3'b000, 3'b001, 3'b100, 3'b101};
  logic [W-1:0] rv[4] = '{16'h0008, 16'h0002, 16'h0000, 16'h0028};

  initial begin
    #1;
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_result", alu_result, 0);
    chk("rst_target", branch_target, 0);
    chk("rst_busy", W'(busy), 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    #1 chk("rel_in_ready", W'(in_ready), 1);

    for (int k = 0; k < 4; k++) begin
      op(2'b10, fv[k], 0, 0, 0, 16'h0005, 16'h0003);
      chk("alu_valid", W'(out_valid), 1);
      chk("alu_lit", alu_result, rv[k]);
    end

    op(2'b01, 0, 1, 16'h0010, 16'hFFFE, 16'h1234, 16'h1234);
    chk("br_zero", W'(zero), 1);
    chk("br_taken", W'(branch_taken), 1);
    chk("br_target", branch_target, 16'h000C);

    op(2'b10, 3'b111, 0, 0, 0, 16'h0012, 16'h0034);
    for (int k = 1; k <= 16; k++) begin
      chk("mul_busy", W'(busy), 1);
      chk("mul_in_ready", W'(in_ready), 0);
      chk("mul_early", W'(out_valid), 0);
      @(posedge clock); #1;
    end
    chk("mul_valid17", W'(out_valid), 1);
    chk("mul_lit", alu_result, 16'h03A8);
    chk("mul_idle", W'(busy), 0);
    @(posedge clock); #1;
    op(2'b10, 3'b111, 0, 0, 0, 16'hFFFF, 16'h0002);
    wait_valid("mul2");
    chk("mul_wrap", alu_result, 16'hFFFE);
    @(posedge clock); #1;

    out_ready = 0;
    op(2'b00, 0, 0, 0, 0, 16'h0100, 16'h0023);
    alu_op = 2'b01; data1 = 16'h0009; data2 = 16'h0004; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", W'(out_valid), 1);
      chk("bp_hold", alu_result, 16'h0123);
      chk("bp_in_ready", W'(in_ready), 0);
      @(posedge clock); #1;
    end
    out_ready = 1;
    #1 chk("bp_release_ready", W'(in_ready), 1);
    @(posedge clock); #1 in_valid = 0;
    chk("bp_next_valid", W'(out_valid), 1);
    chk("bp_next", alu_result, 16'h0005);
    @(posedge clock); #1;

    op(2'b10, 3'b111, 0, 0, 0, 16'h0003, 16'h0004);
    repeat (7) @(posedge clock);
    #1 flush = 1;
    #1 chk("flush_in_ready", W'(in_ready), 0);
    @(posedge clock); #1 flush = 0;
    chk("flush_busy", W'(busy), 0);
    for (int k = 0; k < 20; k++) begin
      chk("flush_no_valid", W'(out_valid), 0);
      @(posedge clock); #1;
    end
    op(2'b00, 0, 0, 0, 0, 16'h0002, 16'h0002);
    chk("post_flush_add", alu_result, 16'h0004);
    @(posedge clock); #1;

    out_ready = 0;
    op(2'b00, 0, 0, 16'h0020, 16'h0001, 16'h0007, 16'h0001);
    chk("pre_rst_valid", W'(out_valid), 1);
    @(posedge clock); #3 reset_n = 0;
    #1;
    chk("mid_rst_valid", W'(out_valid), 0);
    chk("mid_rst_result", alu_result, 0);
    chk("mid_rst_target", branch_target, 0);
    @(posedge clock); #1 reset_n = 1; out_ready = 1;
    #1 chk("mid_rst_in_ready", W'(in_ready), 1);
    repeat (2) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised, registered execute stage for the 16-bit processor family; successor to the combinational EX.
- Computes the ALU result, Zero flag, branch target (PC4 + (imm << 1)) and branch-taken.
- Adds a valid/ready handshake on both sides, an EX/MEM output register, an iterative multi-cycle multiplier and a flush input.
- Sits between the ID/EX register and the MEM stage.

Parameters:
WIDTH, 16, datapath width (address, operands, result); legal values are 8 or more.
FUNCT_W, 3, width of the funct field.
SHAMT_W, 4, number of operand-2 LSBs used as the shift amount; must satisfy 2^SHAMT_W >= WIDTH.

Ports:
clock  in  1  rising-edge clock.
reset_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous; kills the in-flight op and the output register.
in_valid  in  1  ID/EX holds a valid op.
in_ready  out  1  stage accepts an op this cycle.
branch  in  1  op is a conditional branch.
alu_src  in  1  0: operand2 = data2; 1: operand2 = imm.
alu_op  in  2  00 add, 01 sub, 10 R-type by funct, 11 add (immediate).
funct  in  FUNCT_W  R-type function select.
pc4  in  WIDTH  PC+4 of the op.
imm  in  WIDTH  sign-extended immediate.
data1  in  WIDTH  operand 1.
data2  in  WIDTH  register operand 2.
out_valid  out  1  output register holds a result.
out_ready  in  1  MEM consumes the result.
alu_result  out  WIDTH  registered result.
zero  out  1  registered; 1 when alu_result == 0.
branch_target  out  WIDTH  registered pc4 + (imm << 1), modulo 2^WIDTH.
branch_taken  out  1  registered branch & zero.
busy  out  1  multiplier FSM is not IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, alu_result=0, zero=0, branch_target=0, branch_taken=0, busy=0, FSM=IDLE.
- Handshake:
  - in_ready = (state==IDLE) & (!out_valid | out_ready).
  - An op is accepted when in_valid & in_ready.
  - Output transfer happens when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- R-type funct decode: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, result 1 or 0), 101 sll, 110 srl (logical), 111 mul.
- Shifts use only operand2[SHAMT_W-1:0].
- All arithmetic wraps modulo 2^WIDTH; no overflow flag.
- Single-cycle ops: accepted in cycle N; result, zero, target and taken are registered with out_valid=1 at edge N+1.
- mul, FSM states IDLE -> MUL -> IDLE:
  - On accept: latch the multiplicand, multiplier and pc4/imm/branch; set count = WIDTH; go to MUL; busy=1.
  - In MUL, each cycle: if the multiplier LSB is 1, acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count -= 1.
  - When count reaches 0: load the low WIDTH bits of acc into the output register, set out_valid=1, return to IDLE.
  - Latency is WIDTH+1 cycles from accept to out_valid (17 for WIDTH=16).
  - A completing mul waits in MUL, holding its result, if the output register is occupied and not draining.
- branch_taken = branch & zero, computed on the same result. Branches use alu_op=01.
- Flush:
  - Next edge: out_valid=0, FSM=IDLE, busy=0; in_ready=0 during the flush cycle.
  - flush overrides an accept or a completion in the same cycle.
  - The data registers may keep stale values.
- Simultaneous drain and accept in the same cycle is legal: back-to-back throughput is one op per cycle for single-cycle ops.
- Reset asserted mid-mul: immediate return to the reset values; no partial result escapes.

Decomposition:
- Shared package ex_pkg holds:
  - ALUOp constants (ALUOP_ADD/SUB/RTYPE/ADDI);
  - funct constants (F_ADD…F_MUL);
  - FSM state typedef (ST_IDLE, ST_MUL).
- One natural sub-module: ex_iter_mul (shift-add multiplier with start/done, WIDTH-parametrised).
- ALU, ALU control and branch adder stay inline as combinational logic.

Test Plan:
- Reset mid-stream: assert reset_n=0 with out_valid=1 -> all outputs 0 asynchronously, in_ready=1 after release.
- ALU ops (WIDTH=16), alu_op=10, data1=0x0005, data2=0x0003:
  - funct 000 -> 0x0008; 001 -> 0x0002; 100 -> 0x0000; 101 -> 0x0028.
  - Each appears one cycle after accept.
- Branch: alu_op=01, branch=1, data1=data2=0x1234, pc4=0x0010, imm=0xFFFE -> zero=1, branch_taken=1, branch_target=0x000C.
- mul: 0x0012 × 0x0034, then 0xFFFF × 0x0002:
  - First -> busy=1 and in_ready=0 for 16 cycles; out_valid at cycle 17 with result 0x03A8.
  - Second -> 0xFFFE (wrap).
- Backpressure: out_ready=0 for 5 cycles with a result held -> outputs stable, in_ready=0; then out_ready=1 with a new op waiting -> drain and accept in the same cycle.
- Flush: flush at MUL cycle 8 -> out_valid never rises for that op, busy=0 the next cycle, next add completes normally.
